// File: rtl/obstacle_collision_unit.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_collision_unit
//  Description : Scrolling pipe obstacle with LFSR gap placement; detects
//                box/pipe, ceiling and floor hits and pulses collided.
//                Optional score counter enabled by defining SCORE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module obstacle_collision_unit #(
    parameter int         BOX_X     = 20,
    parameter int         BOX_SIZE  = 4,
    parameter int         PIPE_W    = 6,
    parameter int         GAP_H     = 24,
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       game_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic [6:0] y_coordinate,
    output logic       collided,
    output logic [7:0] pipe_x,
    output logic [6:0] gap_y,
    output logic       running,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2
    } state_t;

    localparam logic [7:0] C_PIPE_RESTART = 8'(SCREEN_W - 1);
    localparam logic [6:0] C_GAP_RESET    = 7'd40;
    localparam logic [6:0] C_GAP_MIN      = 7'd8;

    localparam logic [8:0] C_BOX_L     = 9'(BOX_X);
    localparam logic [8:0] C_BOX_R     = 9'(BOX_X + BOX_SIZE - 1);
    localparam logic [8:0] C_PIPE_W_M1 = 9'(PIPE_W - 1);
    localparam logic [8:0] C_BOX_M1    = 9'(BOX_SIZE - 1);
    localparam logic [8:0] C_BOX_SZ    = 9'(BOX_SIZE);
    localparam logic [8:0] C_GAP_M1    = 9'(GAP_H - 1);
    localparam logic [8:0] C_SCR_H     = 9'(SCREEN_H);

    state_t     state_q, state_d;
    logic [7:0] pipe_x_q, pipe_x_d;
    logic [6:0] gap_y_q, gap_y_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       collided_q, collided_d;

    logic [8:0] w_px;
    logic [8:0] w_y;
    logic [8:0] w_gap;
    logic       w_x_ov;
    logic       w_y_out;
    logic       w_bound;
    logic       w_hit;
    logic [7:0] w_lfsr_next;

    // Widened to 9 bits so that none of the edge sums can wrap.
    assign w_px  = {1'b0, pipe_x_q};
    assign w_y   = {2'b00, y_coordinate};
    assign w_gap = {2'b00, gap_y_q};

    assign w_x_ov  = (w_px <= C_BOX_R) && ((w_px + C_PIPE_W_M1) >= C_BOX_L);
    assign w_y_out = (w_y < w_gap) || ((w_y + C_BOX_M1) > (w_gap + C_GAP_M1));
    // Values of 120 and above come from the box register underflowing.
    assign w_bound = (w_y == 9'd0) || ((w_y + C_BOX_SZ) >= C_SCR_H);
    assign w_hit   = (w_x_ov && w_y_out) || w_bound;

    assign w_lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

`ifdef SCORE_EN
    logic [7:0] score_q, score_d;
`endif

    always_comb begin
        state_d    = state_q;
        pipe_x_d   = pipe_x_q;
        gap_y_d    = gap_y_q;
        lfsr_d     = lfsr_q;
        collided_d = 1'b0;
`ifdef SCORE_EN
        score_d    = score_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    pipe_x_d = C_PIPE_RESTART;
`ifdef SCORE_EN
                    score_d  = 8'd0;
`endif
                end
            end
            S_RUN: begin
                if (tick) begin
                    // A hit freezes the obstacle, even on a wrap tick.
                    if (w_hit) begin
                        state_d    = S_HIT;
                        collided_d = 1'b1;
                    end else if (pipe_x_q == 8'd0) begin
                        pipe_x_d = C_PIPE_RESTART;
                        lfsr_d   = w_lfsr_next;
                        gap_y_d  = C_GAP_MIN + {1'b0, w_lfsr_next[5:0]};
`ifdef SCORE_EN
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
`endif
                    end else begin
                        pipe_x_d = pipe_x_q - 8'd1;
                    end
                end
            end
            S_HIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge game_clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pipe_x_q   <= C_PIPE_RESTART;
            gap_y_q    <= C_GAP_RESET;
            lfsr_q     <= LFSR_SEED;
            collided_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pipe_x_q   <= pipe_x_d;
            gap_y_q    <= gap_y_d;
            lfsr_q     <= lfsr_d;
            collided_q <= collided_d;
        end
    end

`ifdef SCORE_EN
    always_ff @(posedge game_clk) begin
        if (reset) begin
            score_q <= 8'd0;
        end else begin
            score_q <= score_d;
        end
    end
    assign score = score_q;
`else
    assign score = 8'd0;
`endif

    assign collided = collided_q;
    assign pipe_x   = pipe_x_q;
    assign gap_y    = gap_y_q;
    assign running  = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_obstacle_collision_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obstacle_collision_unit
//  Description : Directed and randomized bench for obstacle_collision_unit
//                against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_collision_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic       tick;
    logic [6:0] y_coordinate;
    logic       collided;
    logic [7:0] pipe_x;
    logic [6:0] gap_y;
    logic       running;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: mode 0 = idle, 1 = running, 2 = hit
    int m_mode, m_pipe, m_gap, m_lfsr, m_score, m_coll;

    obstacle_collision_unit dut (
        .game_clk     (clk),
        .reset        (reset),
        .start        (start),
        .tick         (tick),
        .y_coordinate (y_coordinate),
        .collided     (collided),
        .pipe_x       (pipe_x),
        .gap_y        (gap_y),
        .running      (running),
        .score        (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit s, input bit t, input int y);
        bit hit;
        int fb;
        if (r) begin
            m_mode = 0; m_pipe = 159; m_gap = 40; m_lfsr = 'hA5; m_score = 0; m_coll = 0;
            return;
        end
        m_coll = 0;
        if (m_mode == 0) begin
            if (s) begin
                m_mode = 1; m_pipe = 159; m_score = 0;
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else if (t) begin
            hit = ((m_pipe <= 23 && m_pipe + 5 >= 20) && (y < m_gap || y + 3 > m_gap + 23))
                  || y == 0 || y + 4 >= 120;
            if (hit) begin
                m_mode = 2; m_coll = 1;
            end else if (m_pipe == 0) begin
                m_pipe = 159;
                fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
                m_lfsr = ((m_lfsr << 1) | fb) & 255;
                m_gap = 8 + (m_lfsr % 64);
                if (m_score < 255) m_score++;
            end else begin
                m_pipe--;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit t, input int y);
        reset = r; start = s; tick = t; y_coordinate = 7'(y);
        @(posedge clk);
        model(r, s, t, y);
        #1;
        check("collided", 32'(collided), 32'(m_coll));
        check("pipe_x", 32'(pipe_x), 32'(m_pipe));
        check("gap_y", 32'(gap_y), 32'(m_gap));
        check("running", 32'(running), 32'(m_mode == 1));
`ifdef SCORE_EN
        check("score", 32'(score), 32'(m_score));
`else
        check("score", 32'(score), 32'd0);
`endif
    endtask

    initial begin
        int y;
        bit found;
        reset = 1'b0; start = 1'b0; tick = 1'b0; y_coordinate = 7'd50;
        m_mode = 0; m_pipe = 0; m_gap = 0; m_lfsr = 0; m_score = 0; m_coll = 0;
        @(negedge clk);

        // Reset values and a full scroll with one wrap
        step(1, 0, 0, 50);
        check("rst_pipe_x", 32'(pipe_x), 32'd159);
        check("rst_gap_y", 32'(gap_y), 32'd40);
        check("rst_running", 32'(running), 32'd0);
        check("rst_collided", 32'(collided), 32'd0);
        step(0, 1, 0, 50);
        for (int i = 0; i < 160; i++) step(0, 0, 1, 50);
        check("t1_pipe_x", 32'(pipe_x), 32'd159);
        check("t1_gap_y", 32'(gap_y), 32'd18);
        check("t1_running", 32'(running), 32'd1);
`ifdef SCORE_EN
        check("t1_score", 32'(score), 32'd1);
`else
        check("t1_score", 32'(score), 32'd0);
`endif

        // Box below the gap collides once the pipe reaches its right edge
        step(1, 0, 0, 61);
        step(0, 1, 0, 61);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(0, 0, 1, 61);
            found = (m_coll == 1);
        end
        check("t2_hit_seen", 32'(found), 32'd1);
        check("t2_hit_collided", 32'(collided), 32'd1);
        check("t2_hit_pipe_x", 32'(pipe_x), 32'd23);
        step(0, 0, 1, 61);
        check("t2_after_collided", 32'(collided), 32'd0);
        check("t2_after_pipe_x", 32'(pipe_x), 32'd23);
        check("t2_after_running", 32'(running), 32'd0);

        // Ceiling and floor bounds
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        check("t3_ceiling", 32'(collided), 32'd1);
        step(0, 0, 0, 117);
        step(0, 1, 0, 117);
        step(0, 0, 1, 117);
        check("t3_floor", 32'(collided), 32'd1);
        step(0, 0, 0, 50);
        step(0, 1, 0, 50);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 50);
        check("t3_pipe_100", 32'(pipe_x), 32'd100);
        step(0, 0, 1, 115);
        check("t3_low_ok", 32'(collided), 32'd0);

        // Mid-run reset
        for (int i = 0; i < 19; i++) step(0, 0, 1, 50);
        check("t4_pipe_80", 32'(pipe_x), 32'd80);
        step(1, 0, 0, 50);
        check("t4_pipe_x", 32'(pipe_x), 32'd159);
        check("t4_gap_y", 32'(gap_y), 32'd40);
        check("t4_running", 32'(running), 32'd0);
        check("t4_collided", 32'(collided), 32'd0);

        // Ignored inputs per state
        for (int i = 0; i < 10; i++) step(0, 0, 1, 50);
        check("t5_idle_pipe", 32'(pipe_x), 32'd159);
        step(0, 1, 0, 50);
        for (int i = 0; i < 6; i++) step(0, 1, i % 2, 50);
        check("t5_run_pipe", 32'(pipe_x), 32'd156);
        check("t5_run_running", 32'(running), 32'd1);
        step(0, 1, 1, 0);
        check("t5_hit_collided", 32'(collided), 32'd1);
        step(0, 1, 1, 50);
        check("t5_hit_idle", 32'(running), 32'd0);
        step(0, 0, 1, 50);
        check("t5_idle_stays", 32'(running), 32'd0);

        // Randomized play
        step(1, 0, 0, 50);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) y = $urandom_range(0, 127);
            else y = m_gap + $urandom_range(0, 20);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, y);
        end

`ifdef SCORE_EN
        // Score saturation over 256 wraps
        step(1, 0, 0, 50);
        step(0, 1, 0, 50);
        for (int i = 0; i < 256 * 160; i++) step(0, 0, 1, m_gap + 10);
        check("t6_score_sat", 32'(score), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
